// File: rtl/ehl_deserializer.sv
// ehl_deserializer: assembles a qualified serial stream into WIDTH-bit words, per-word MSB/LSB-first order, valid/ready output
module ehl_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             msb_first,
  input  logic             sclr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             ord;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] nxt_sr;
  logic             acc;
  logic             done;
  logic             cur_ord;
  // the first bit of a word uses msb_first directly; later bits use the latched order
  always_comb begin
    cur_ord = state == IDLE ? msb_first : ord;
    nxt_sr  = cur_ord ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
    acc     = sin_valid && !sclr;
    done    = acc && cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ord        <= 1'b0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= done && dout_valid && !dout_ready;
      if (sclr) begin
        state <= IDLE;
        cnt   <= '0;
        sr    <= '0;
      end else if (sin_valid) begin
        sr    <= nxt_sr;
        ord   <= cur_ord;
        cnt   <= done ? '0 : cnt + CW'(1);
        state <= done ? IDLE : SHIFT;
      end
      // a completing word may replace one being consumed in the same cycle
      if (done && (!dout_valid || dout_ready)) begin
        dout       <= nxt_sr;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule
